vram_arbiter: RTL and testbench

- Shares one single-port on-chip pixel RAM (320x240, 8-bit colour) among three clients:
  - vga_sync scan-out reads;
  - maze drawing-engine writes;
  - an internal clear sequencer that fills the whole frame with one colour.
- Sits between the maze logic, the pixel RAM and the colour mux that feeds vga_sync.
- Display reads have absolute priority. The maze display path uses horizontal pixel doubling, so the display requests at most every other cycle during active video, which leaves slots for the other clients.

---
 rtl/vram_pkg.sv | 22 ++
 rtl/vram_clear_seq.sv | 75 +++++++
 rtl/vram_arbiter.sv | 139 +++++++++++++
 tb/tb_vram_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared constants and enums for the pixel RAM arbiter.
// Frame geometry, grant encoding and clear-sequencer states.
package vram_pkg;

  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_DEPTH  = FB_W * FB_H;
  localparam int FB_ADDR_W = 17;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DISP,
    GNT_WR,
    GNT_CLR
  } gnt_e;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_e;

endpackage

// File: rtl/vram_clear_seq.sv
// Full-frame clear sequencer: FSM, sweep counter, colour latch.
// Ports: clk/rst, clear pulse + colour, grant_clr in; busy/addr/color out.
module vram_clear_seq
  import vram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DEPTH  = FB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] clear_color,
  input  logic              grant_clr,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] color
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] col_q, col_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
    end
  end

  // A new clear pulse wins over the sweep step; the write of
  // that cycle still uses cnt_q/col_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    unique case (state_q)
      CLR_IDLE: begin
        if (clear) begin
          state_d = CLR_RUN;
          cnt_d   = '0;
          col_d   = clear_color;
        end
      end
      CLR_RUN: begin
        if (clear) begin
          cnt_d = '0;
          col_d = clear_color;
        end else if (grant_clr) begin
          if (cnt_q == LAST) begin
            state_d = CLR_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == CLR_RUN);
    addr  = cnt_q;
    color = col_q;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port pixel RAM arbiter: display > writer > clear sequencer.
// Ports: display read, writer handshake, clear control, flags, RAM port.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int DEPTH    = FB_DEPTH,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 64
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iDisp_req,
  input  logic [ADDR_W-1:0] iDisp_addr,
  output logic [DATA_W-1:0] oDisp_data,
  output logic              oDisp_valid,
  input  logic              iWr_valid,
  input  logic [ADDR_W-1:0] iWr_addr,
  input  logic [DATA_W-1:0] iWr_data,
  output logic              oWr_ready,
  input  logic              iClear,
  input  logic [DATA_W-1:0] iClear_color,
  output logic              oClear_busy,
  output logic              oOverrun,
  output logic              oAddr_err,
  output logic [ADDR_W-1:0] oMem_addr,
  output logic [DATA_W-1:0] oMem_wdata,
  output logic              oMem_we,
  input  logic [DATA_W-1:0] iMem_rdata
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam int                WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MX = WAIT_W'(MAX_WAIT);

  gnt_e              gnt;
  logic              wr_oor;
  logic              wr_hs;
  logic              clr_busy;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_color;

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] oor_q, oor_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ovr_q, ovr_d;
  logic              aerr_q, aerr_d;

  assign wr_oor    = (iWr_addr >= DEPTH_A);
  assign oWr_ready = ~iRST & ~iDisp_req;
  assign wr_hs     = iWr_valid & oWr_ready;

  // An out-of-range write still owns its slot, so it never
  // falls through to the clear sequencer.
  always_comb begin
    gnt = GNT_NONE;
    if (!iRST) begin
      if (iDisp_req)     gnt = GNT_DISP;
      else if (iWr_valid) gnt = GNT_WR;
      else if (clr_busy)  gnt = GNT_CLR;
    end
  end

  always_comb begin
    oMem_addr  = '0;
    oMem_wdata = '0;
    oMem_we    = 1'b0;
    unique case (gnt)
      GNT_DISP: oMem_addr = iDisp_addr;
      GNT_WR: begin
        oMem_addr  = iWr_addr;
        oMem_wdata = iWr_data;
        oMem_we    = ~wr_oor;
      end
      GNT_CLR: begin
        oMem_addr  = clr_addr;
        oMem_wdata = clr_color;
        oMem_we    = 1'b1;
      end
      default: ;
    endcase
  end

  vram_clear_seq #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr (
    .clk         (iCLK),
    .rst         (iRST),
    .clear       (iClear),
    .clear_color (iClear_color),
    .grant_clr   (gnt == GNT_CLR),
    .busy        (clr_busy),
    .addr        (clr_addr),
    .color       (clr_color)
  );

  assign oClear_busy = clr_busy;

  always_comb begin
    vld_d    = vld_q << 1;
    oor_d    = oor_q << 1;
    vld_d[0] = iDisp_req;
    oor_d[0] = (iDisp_addr >= DEPTH_A);
  end

  always_comb begin
    wait_d = wait_q;
    if (!iWr_valid || wr_hs) wait_d = '0;
    else if (wait_q != WAIT_MX) wait_d = wait_q + 1'b1;
    ovr_d  = ovr_q | (wait_d == WAIT_MX);
    aerr_d = aerr_q | (wr_hs & wr_oor);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      vld_q  <= '0;
      oor_q  <= '0;
      wait_q <= '0;
      ovr_q  <= 1'b0;
      aerr_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      oor_q  <= oor_d;
      wait_q <= wait_d;
      ovr_q  <= ovr_d;
      aerr_q <= aerr_d;
    end
  end

  assign oDisp_valid = vld_q[RD_LAT-1];
  assign oDisp_data  = (vld_q[RD_LAT-1] && !oor_q[RD_LAT-1]) ?
                       iMem_rdata : '0;
  assign oOverrun    = ovr_q;
  assign oAddr_err   = aerr_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a 1-cycle RAM model.
// Uses a reduced frame depth so full clears stay short.
module tb_vram_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 17;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          clr;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          overrun;
  logic          addr_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [DEPTH];
  int            hits [DEPTH];
  bit            hit_en = 0;
  bit            cnt_en = 0;
  int            vcnt = 0;
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  vram_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
    .RD_LAT(1), .MAX_WAIT(64)
  ) dut (
    .iCLK(clk), .iRST(rst),
    .iDisp_req(disp_req), .iDisp_addr(disp_addr),
    .oDisp_data(disp_data), .oDisp_valid(disp_valid),
    .iWr_valid(wr_valid), .iWr_addr(wr_addr),
    .iWr_data(wr_data), .oWr_ready(wr_ready),
    .iClear(clr), .iClear_color(clr_color),
    .oClear_busy(clr_busy), .oOverrun(overrun),
    .oAddr_err(addr_err), .oMem_addr(mem_addr),
    .oMem_wdata(mem_wdata), .oMem_we(mem_we),
    .iMem_rdata(mem_rdata)
  );

  // RAM model: registered read, out-of-range reads return junk
  always @(posedge clk) begin
    if (mem_we && mem_addr < AW'(DEPTH)) mem[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_addr < AW'(DEPTH)) ? mem[mem_addr] : 8'hEE;
  end

  // Clear-slot writes, derived from bench inputs and priority order
  always @(posedge clk) begin
    if (hit_en && mem_we && !disp_req && !wr_valid &&
        mem_addr < AW'(DEPTH))
      hits[mem_addr] <= hits[mem_addr] + 1;
    if (cnt_en && disp_valid) vcnt <= vcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    int cycles, reqs, stolen, wr_sent, bad;
    logic [AW-1:0] last_addr;
    bit rq, wq;

    rst = 1; disp_req = 0; disp_addr = '0; wr_valid = 0;
    wr_addr = '0; wr_data = '0; clr = 0; clr_color = '0;
    repeat (2) cyc();
    #1;
    chk("rst_ready", wr_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_flags", {overrun, addr_err, disp_valid}, 0);
    cyc(); rst = 0;

    // preload word 5 through the writer
    wr_valid = 1; wr_addr = 5; wr_data = 8'h3C;
    cyc(); wr_valid = 0;
    disp_req = 1; disp_addr = 5;
    #1;
    chk("rd_we", mem_we, 0);
    chk("rd_addr", mem_addr, 5);
    cyc(); disp_req = 0;
    chk("rd_valid", disp_valid, 1);
    chk("rd_data", disp_data, 8'h3C);
    cyc();
    chk("rd_valid_off", disp_valid, 0);

    // write blocked by display, then accepted
    disp_req = 1; disp_addr = 7;
    wr_valid = 1; wr_addr = 100; wr_data = 8'hA5;
    #1;
    chk("wr_blk_ready", wr_ready, 0);
    chk("wr_blk_we", mem_we, 0);
    cyc(); disp_req = 0;
    #1;
    chk("wr_ready", wr_ready, 1);
    chk("wr_port", {mem_we, mem_addr, mem_wdata}, {1'b1, 17'd100, 8'hA5});
    cyc(); wr_valid = 0;
    disp_req = 1; disp_addr = 100;
    cyc(); disp_req = 0;
    chk("wr_readback", disp_data, 8'hA5);

    // out-of-range write and read
    wr_valid = 1; wr_addr = AW'(DEPTH); wr_data = 8'h77;
    #1;
    chk("oor_ready", wr_ready, 1);
    chk("oor_we", mem_we, 0);
    chk("oor_err_pre", addr_err, 0);
    cyc(); wr_addr = 17'd76800;
    chk("oor_err", addr_err, 1);
    cyc(); wr_valid = 0;
    disp_req = 1; disp_addr = AW'(DEPTH);
    #1;
    chk("oor_rd_addr", mem_addr, DEPTH);
    cyc(); disp_req = 0;
    chk("oor_rd_valid", disp_valid, 1);
    chk("oor_rd_data", disp_data, 0);

    // plain clear
    clr = 1; clr_color = 8'h1F;
    cyc(); clr = 0; clr_color = 8'h00;
    cycles = 0; last_addr = '0;
    while (clr_busy && cycles < DEPTH + 8) begin
      #1;
      if (mem_we) last_addr = mem_addr;
      cycles++;
      cyc();
    end
    chk("clr_cycles", cycles, DEPTH);
    chk("clr_last_addr", last_addr, DEPTH - 1);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== 8'h1F) bad++;
    chk("clr_fill", bad, 0);
    chk("addr_err_sticky", addr_err, 1);

    // clear with display and writer traffic
    cnt_en = 1; vcnt = 0;
    clr = 1; clr_color = 8'h42;
    cyc(); clr = 0; hit_en = 1;
    cycles = 0; reqs = 0; stolen = 0; wr_sent = 0;
    while (clr_busy && cycles < 2 * DEPTH + 64) begin
      rq = (cycles % 2) == 0;
      wq = !rq && wr_sent < 10;
      disp_req = rq; disp_addr = AW'(cycles % DEPTH);
      wr_valid = wq; wr_addr = AW'(10 + wr_sent); wr_data = 8'h99;
      if (rq) reqs++;
      if (rq || wq) stolen++;
      if (wq) wr_sent++;
      cycles++;
      cyc();
    end
    disp_req = 0; wr_valid = 0; hit_en = 0;
    chk("mix_cycles", cycles, DEPTH + stolen);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (hits[i] != 1) bad++;
    chk("mix_once", bad, 0);
    repeat (2) cyc();
    cnt_en = 0;
    chk("mix_valids", vcnt, reqs);

    // overrun watchdog
    disp_req = 1; wr_valid = 1; wr_addr = 3; wr_data = 8'h01;
    repeat (63) cyc();
    chk("ovr_63", overrun, 0);
    cyc();
    chk("ovr_64", overrun, 1);
    repeat (6) cyc();
    disp_req = 0; wr_valid = 0;
    cyc();
    chk("ovr_sticky", overrun, 1);

    // reset mid-clear with a read in flight
    clr = 1; clr_color = 8'h05;
    cyc(); clr = 0;
    repeat (50) cyc();
    chk("mid_busy", clr_busy, 1);
    disp_req = 1; disp_addr = 3; rst = 1;
    cyc(); disp_req = 0;
    chk("mrst_busy", clr_busy, 0);
    chk("mrst_flags", {overrun, addr_err}, 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mrst_valid", disp_valid, 0);
    end
    chk("mrst_idle", clr_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
